program_loader: RTL and testbench

//  Host-side initiator for the processor load/run/dump port (addr/wEn/wDat/working/rID/rdata).
//  - Accepts a program as a valid/ready word stream and writes it into instruction memory from address 0.
//  - Asserts working for a programmed number of cycles.
//  - Reads back registers 0..NUM_REGS-1 and emits them as a valid/ready result stream.
//  - Sits between the host/test harness and the processor; replaces hand-sequenced bench stimulus.

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 181 ++++++++++++++++++
 tb/tb_program_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Bus bundle between the program loader and the processor load/run/dump port,
// including the host-side program input stream and the result output stream.
interface program_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RID_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] addr;
  logic              wEn;
  logic [DATA_W-1:0] wDat;
  logic              working;
  logic [RID_W-1:0]  rID;
  logic [DATA_W-1:0] rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RID_W-1:0]  out_idx;

  modport master (
    input  in_valid, in_data, rdata, out_ready,
    output in_ready, addr, wEn, wDat, working, rID, out_valid, out_data, out_idx
  );

  modport slave (
    output in_valid, in_data, rdata, out_ready,
    input  in_ready, addr, wEn, wDat, working, rID, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/program_loader.sv
// Host-side sequencer: streams a program into instruction memory, runs the
// processor for a fixed number of cycles, then dumps the register file.
module program_loader #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int RID_W    = 4,
  parameter int NUM_REGS = 6,
  parameter int RUN_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [RUN_W-1:0]  run_cycles,
  program_loader_if.master  bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_GAP,
    S_DUMP_RD,
    S_DUMP_OUT
  } state_e;

  localparam logic [ADDR_W:0]  LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [RID_W-1:0] RID_ONE  = {{(RID_W-1){1'b0}}, 1'b1};
  localparam logic [RID_W-1:0] LAST_RID = RID_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              working_q, working_d;
  logic [RID_W-1:0]  rid_q, rid_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [RID_W-1:0]  out_idx_q, out_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    run_cnt_d   = run_cnt_q;
    in_ready_d  = in_ready_q;
    addr_d      = addr_q;
    wen_d       = 1'b0;
    wdat_d      = wdat_q;
    working_d   = working_q;
    rid_d       = rid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = prog_len;
          run_cnt_d = run_cycles;
          cnt_d     = '0;
          rid_d     = '0;
          busy_d    = 1'b1;
          if (prog_len == '0) begin
            state_d = S_SETTLE;
          end else begin
            state_d    = S_LOAD;
            in_ready_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          // cnt is one bit wider than addr so a full-memory load terminates cleanly
          addr_d = cnt_q[ADDR_W-1:0];
          wdat_d = bus.in_data;
          wen_d  = 1'b1;
          cnt_d  = cnt_q + LEN_ONE;
          if (cnt_d == len_q) begin
            in_ready_d = 1'b0;
            state_d    = S_SETTLE;
          end
        end
      end
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        if (run_cnt_q != '0) begin
          working_d = 1'b1;
          run_cnt_d = run_cnt_q - RUN_ONE;
        end else begin
          working_d = 1'b0;
          state_d   = S_GAP;
        end
      end
      S_GAP: state_d = S_DUMP_RD;
      S_DUMP_RD: begin
        out_data_d  = bus.rdata;
        out_idx_d   = rid_q;
        out_valid_d = 1'b1;
        state_d     = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (rid_q == LAST_RID) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            rid_d   = rid_q + RID_ONE;
            state_d = S_DUMP_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      run_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdat_q      <= '0;
      working_q   <= 1'b0;
      rid_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      run_cnt_q   <= run_cnt_d;
      in_ready_q  <= in_ready_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdat_q      <= wdat_d;
      working_q   <= working_d;
      rid_q       <= rid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.addr      = addr_q;
  assign bus.wEn       = wen_q;
  assign bus.wDat      = wdat_q;
  assign bus.working   = working_q;
  assign bus.rID       = rid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a table of load/run/dump scenarios
// plus hand-written reset, held-start and abort sequences.
module tb_program_loader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int RID_W  = 4;
  localparam logic [5:0][31:0] DUMP = {32'h00000021, 32'h00000020, 32'h0000001f,
                                        32'hffffffff, 32'h00000056, 32'h00000039};

  typedef struct packed {
    int              len;
    int              runc;
    logic            bubbly;
    logic            bp;
    int              exp_writes;
    int              exp_work;
    int              exp_rise;
    int              exp_stall;
    logic [5:0][31:0] exp_dump;
  } vec_t;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic [15:0]       run_cycles;
  logic              busy;
  logic              done;

  program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RID_W(RID_W)) iface ();

  program_loader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .bus        (iface),
    .busy       (busy),
    .done       (done)
  );

  logic [31:0] regs [16];
  logic [31:0] prog [512];
  logic [31:0] imem [512];
  assign iface.rdata = regs[iface.rID];

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor statistics, cleared whenever a new sequence bumps seq_id.
  int seq_id = 0, seen_id = -1;
  int wr_cnt, addr_err, work_cnt, work_rise, gap_err, stall_cnt, stab_err;
  int res_cnt, done_cnt, done_err;
  logic [31:0] res_data [6];
  logic [3:0]  res_idx  [6];
  logic prev_work, prev_wen, prev_ov, prev_or;
  logic [31:0] prev_od;
  logic [3:0]  prev_oi;

  always begin
    @(negedge clock);
    #1;
    if (seq_id != seen_id) begin
      seen_id = seq_id;
      wr_cnt = 0; addr_err = 0; work_cnt = 0; work_rise = 0; gap_err = 0;
      stall_cnt = 0; stab_err = 0; res_cnt = 0; done_cnt = 0; done_err = 0;
      for (int i = 0; i < 512; i++) imem[i] = 32'hdeadbeef;
      for (int i = 0; i < 6; i++) begin
        res_data[i] = 32'hdeaddead;
        res_idx[i]  = 4'hf;
      end
    end
    if (iface.wEn === 1'b1) begin
      if (int'(iface.addr) != wr_cnt) addr_err++;
      imem[iface.addr] = iface.wDat;
      wr_cnt++;
    end
    if (iface.working === 1'b1) begin
      work_cnt++;
      if (prev_work !== 1'b1) work_rise++;
      if (iface.wEn === 1'b1 || prev_wen === 1'b1) gap_err++;
    end
    if (iface.out_valid === 1'b1 && iface.out_ready !== 1'b1) stall_cnt++;
    if (prev_ov === 1'b1 && prev_or !== 1'b1 &&
        (iface.out_valid !== 1'b1 || iface.out_data !== prev_od || iface.out_idx !== prev_oi))
      stab_err++;
    if (iface.out_valid === 1'b1 && iface.out_ready === 1'b1) begin
      if (res_cnt < 6) begin
        res_data[res_cnt] = iface.out_data;
        res_idx[res_cnt]  = iface.out_idx;
      end
      res_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_err++;
    end
    prev_work = iface.working;
    prev_wen  = iface.wEn;
    prev_ov   = iface.out_valid;
    prev_or   = iface.out_ready;
    prev_od   = iface.out_data;
    prev_oi   = iface.out_idx;
  end

  task automatic feed(input int len, input bit bubbly);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (idx < len && guard < 3000) begin
      iface.in_valid = bubbly ? ph : 1'b1;
      iface.in_data  = prog[idx];
      ph = ~ph;
      if (iface.in_valid && iface.in_ready) idx++;
      @(negedge clock);
      guard++;
    end
    iface.in_valid = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int waits = 0;
    int guard = 0;
    iface.out_ready = ~bp;
    while (done_cnt == 0 && guard < 3000) begin
      @(negedge clock);
      guard++;
      if (iface.out_valid) begin
        if (bp && waits < 5) begin
          iface.out_ready = 1'b0;
          waits++;
        end else begin
          iface.out_ready = 1'b1;
          waits = 0;
        end
      end else begin
        iface.out_ready = ~bp;
      end
    end
  endtask

  // start is presented together with in_valid to show IDLE ignores the word.
  task automatic run_seq(input vec_t v);
    seq_id++;
    @(negedge clock);
    iface.in_valid  = 1'b1;
    iface.in_data   = 32'hbad0bad0;
    iface.out_ready = 1'b0;
    prog_len   = v.len[ADDR_W:0];
    run_cycles = v.runc[15:0];
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    fork
      feed(v.len, v.bubbly);
      drain(v.bp);
    join
    repeat (4) @(negedge clock);
  endtask

  task automatic verify(input vec_t v, input string tag);
    int bad = 0;
    for (int i = 0; i < v.len; i++) if (imem[i] !== prog[i]) bad++;
    check({tag, " writes"}, wr_cnt, v.exp_writes);
    check({tag, " addr_order_errs"}, addr_err, 0);
    check({tag, " imem_mismatches"}, bad, 0);
    check({tag, " working_cycles"}, work_cnt, v.exp_work);
    check({tag, " working_rises"}, work_rise, v.exp_rise);
    check({tag, " write_working_overlap"}, gap_err, 0);
    check({tag, " stall_cycles"}, stall_cnt, v.exp_stall);
    check({tag, " unstable_outputs"}, stab_err, 0);
    check({tag, " results"}, res_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s dump%0d data", tag, i), res_data[i], v.exp_dump[i]);
      check($sformatf("%s dump%0d idx", tag, i), {28'd0, res_idx[i]}, i);
    end
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_during_done"}, done_err, 0);
    check({tag, " busy_after"}, {31'd0, busy}, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int guard;

    for (int i = 0; i < 16; i++) regs[i] = 32'heeee0000 + i;
    regs[0] = 32'h00000039; regs[1] = 32'h00000056; regs[2] = 32'hffffffff;
    regs[3] = 32'h0000001f; regs[4] = 32'h00000020; regs[5] = 32'h00000021;
    for (int i = 0; i < 512; i++) prog[i] = 32'ha5000000 + i;
    prog[0] = 32'h10f0001c; prog[1] = 32'h10f1001d; prog[2] = 32'h10f2001e;
    prog[3] = 32'h10f3001f; prog[4] = 32'h10f40020; prog[5] = 32'h10f50021;
    prog[6] = 32'h20010000; prog[7] = 32'h21230000; prog[8] = 32'h32450000;
    prog[9] = 32'h20100000;

    //          len  runc bub bp  writes work rise stall dump
    vecs[0] = '{10,  13,  0,  0,  10,    13,  1,   0,    DUMP};
    vecs[1] = '{10,  13,  1,  0,  10,    13,  1,   0,    DUMP};
    vecs[2] = '{10,  13,  0,  1,  10,    13,  1,   30,   DUMP};
    vecs[3] = '{0,   0,   0,  0,  0,     0,   0,   0,    DUMP};
    vecs[4] = '{512, 2,   0,  0,  512,   2,   1,   0,    DUMP};
    vecs[5] = '{1,   1,   1,  1,  1,     1,   1,   30,   DUMP};

    reset_n = 1'b0;
    start = 1'b0;
    prog_len = '0;
    run_cycles = '0;
    iface.in_valid = 1'b0;
    iface.in_data = '0;
    iface.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset in_ready", {31'd0, iface.in_ready}, 0);
    check("reset wEn", {31'd0, iface.wEn}, 0);
    check("reset working", {31'd0, iface.working}, 0);
    check("reset out_valid", {31'd0, iface.out_valid}, 0);
    check("reset addr", {23'd0, iface.addr}, 0);
    check("reset wDat", iface.wDat, 0);
    check("reset rID", {28'd0, iface.rID}, 0);
    check("reset out_idx", {28'd0, iface.out_idx}, 0);
    check("reset out_data", iface.out_data, 0);

    for (int s = 0; s < 6; s++) begin
      run_seq(vecs[s]);
      verify(vecs[s], $sformatf("vec%0d", s));
    end

    // start held high across the whole sequence: exactly one run.
    seq_id++;
    @(negedge clock);
    prog_len = '0;
    run_cycles = 16'd3;
    iface.out_ready = 1'b1;
    start = 1'b1;
    guard = 0;
    while (done !== 1'b1 && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    start = 1'b0;
    repeat (40) @(negedge clock);
    check("held done_pulses", done_cnt, 1);
    check("held working_cycles", work_cnt, 3);
    check("held working_rises", work_rise, 1);
    check("held results", res_cnt, 6);
    check("held busy_after", {31'd0, busy}, 0);

    // Asynchronous reset in the middle of RUN aborts the sequence.
    seq_id++;
    @(negedge clock);
    prog_len = '0;
    run_cycles = 16'd20;
    iface.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (iface.working !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("abort reached working", {31'd0, iface.working}, 1);
    repeat (3) @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("abort working", {31'd0, iface.working}, 0);
    check("abort busy", {31'd0, busy}, 0);
    check("abort out_valid", {31'd0, iface.out_valid}, 0);
    check("abort wEn", {31'd0, iface.wEn}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("abort results", res_cnt, 0);
    check("abort done_pulses", done_cnt, 0);
    check("abort busy_after", {31'd0, busy}, 0);

    run_seq(vecs[0]);
    verify(vecs[0], "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
